// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus FSM encoding and transfer-direction constants
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } bus_state_t;

    localparam logic BUS_RD = 1'b1;
    localparam logic BUS_WR = 1'b0;

endpackage

// File: rtl/bus_sram_slave_if.sv
// rtl/bus_sram_slave_if.sv - master-driven request/address/direction signals of the system bus
interface bus_sram_slave_if;

    logic [31:0] BUS_addr;
    logic        BUS_req;
    logic        BUS_RW;

    modport master (output BUS_addr, output BUS_req, output BUS_RW);
    modport slave  (input  BUS_addr, input  BUS_req, input  BUS_RW);

endinterface

// File: rtl/bus_sram_slave_sram_1rw.sv
// rtl/bus_sram_slave_sram_1rw.sv - single-port 32-bit RAM, synchronous write, registered read
module sram_1rw #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [0:(1<<ADDR_W)-1];
    logic [31:0] r_rdata;

    // Contents are never cleared; write and read share the one address port
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_sram_slave.sv
// rtl/bus_sram_slave.sv - windowed SRAM bus target with wait states; SLAVE_STATS_EN adds rd/wr counters
module bus_sram_slave #(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            clr,
    bus_sram_slave_if.slave bus,
    inout  wire  [31:0]     BUS_data,
    inout  wire             BUS_ready
`ifdef SLAVE_STATS_EN
    ,
    output logic [15:0]     rd_count,
    output logic [15:0]     wr_count
`endif
);

    import bus_pkg::*;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    bus_state_t        r_state;
    bus_state_t        w_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic [ADDR_W-1:0] r_idx;
    logic              r_rw;
    logic [31:0]       r_wdata;

    logic              w_hit;
    logic              w_accept;
    logic              w_ack;
    logic [ADDR_W-1:0] w_bus_idx;
    logic [ADDR_W-1:0] w_mem_idx;
    logic              w_cur_rw;
    logic              w_we;
    logic              w_re;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_hit     = (bus.BUS_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
    assign w_bus_idx = bus.BUS_addr[ADDR_W+1:2];
    assign w_unused  = &{1'b0, bus.BUS_addr[1:0]};
    assign w_ack     = (r_state == ST_ACK);

    // State register and capture of the accepted request; later bus changes are ignored
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_rw    <= BUS_RD;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_idx   <= w_bus_idx;
                r_rw    <= bus.BUS_RW;
                r_wdata <= BUS_data;
            end
        end
    end

    // Next state: accept on hit, count wait states, one-cycle ACK, 4-phase release in HOLD
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.BUS_req && w_hit) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_next = ST_ACK;
                    end else begin
                        w_next     = ST_WAIT;
                        w_cnt_next = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.BUS_req) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next = ST_ACK;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                w_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (!bus.BUS_req) begin
                    w_next = ST_IDLE;
                end
            end
        endcase
    end

    // The read is launched on the edge into ACK so the data is ready while BUS_ready is high;
    // in IDLE (zero wait states) the address and direction come straight off the bus.
    assign w_cur_rw  = (r_state == ST_IDLE) ? bus.BUS_RW : r_rw;
    assign w_mem_idx = (r_state == ST_IDLE) ? w_bus_idx : r_idx;
    assign w_re      = (w_next == ST_ACK) && (w_cur_rw == BUS_RD);
    assign w_we      = w_ack && (r_rw == BUS_WR);

    sram_1rw #(
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_mem_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign BUS_ready = w_ack ? 1'b1 : 1'bz;
    assign BUS_data  = (w_ack && (r_rw == BUS_RD)) ? w_rdata : 32'bz;

`ifdef SLAVE_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    // Saturating completion counters; a transfer counts only once it leaves ACK
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else if (w_ack) begin
            if (r_rw == BUS_RD) begin
                if (r_rd_count != 16'hFFFF) begin
                    r_rd_count <= r_rd_count + 16'd1;
                end
            end else begin
                if (r_wr_count != 16'hFFFF) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_bus_sram_slave.sv
// tb/tb_bus_sram_slave.sv - directed bench: two slaves (2 and 0 wait states) sharing one bus
module tb_bus_sram_slave;

    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        m_drive;
    logic [31:0] m_wdata;
    int          n_pass  = 0;
    int          n_total = 0;

    wire  [31:0] bus_data;
    wire         bus_ready;

    bus_sram_slave_if bus_if ();

    pullup   (bus_data);
    pulldown (bus_ready);
    assign bus_data = m_drive ? m_wdata : 32'bz;

`ifdef SLAVE_STATS_EN
    logic [15:0] stat_rd;
    logic [15:0] stat_wr;
    logic [15:0] stat_rd0;
    logic [15:0] stat_wr0;
`endif

    always #5 clk = ~clk;

    bus_sram_slave #(.ADDR_W(10), .BASE(32'h0000_0000), .WAIT_STATES(2)) u_ws2 (
        .clk       (clk),
        .clr       (clr),
        .bus       (bus_if),
        .BUS_data  (bus_data),
        .BUS_ready (bus_ready)
`ifdef SLAVE_STATS_EN
        ,
        .rd_count  (stat_rd),
        .wr_count  (stat_wr)
`endif
    );

    bus_sram_slave #(.ADDR_W(10), .BASE(32'h0000_1000), .WAIT_STATES(0)) u_ws0 (
        .clk       (clk),
        .clr       (clr),
        .bus       (bus_if),
        .BUS_data  (bus_data),
        .BUS_ready (bus_ready)
`ifdef SLAVE_STATS_EN
        ,
        .rd_count  (stat_rd0),
        .wr_count  (stat_wr0)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit corrupt, output logic [31:0] rdata, output int lat,
                        output bit rel_pre, output bit rel_post);
        bit seen;
        seen  = 1'b0;
        lat   = 0;
        rdata = 32'd0;
        @(negedge clk);
        bus_if.BUS_addr = addr;
        bus_if.BUS_RW   = rw;
        bus_if.BUS_req  = 1'b1;
        m_wdata         = wdata;
        m_drive         = (rw == BUS_WR);
        #1;
        rel_pre = (bus_ready === 1'b0) && ((rw == BUS_WR) || (bus_data === 32'hFFFF_FFFF));
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus_ready === 1'b1) begin
                seen  = 1'b1;
                rdata = bus_data;
            end else if (corrupt) begin
                bus_if.BUS_addr = addr ^ 32'h4;
                m_wdata         = ~wdata;
            end
        end
        if (!seen) lat = 99;
        @(negedge clk);
        bus_if.BUS_req  = 1'b0;
        bus_if.BUS_addr = 32'h0;
        m_drive         = 1'b0;
        @(posedge clk);
        #1;
        rel_post = (bus_data === 32'hFFFF_FFFF) && (bus_ready === 1'b0);
        @(posedge clk);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input int exp_lat, input bit corrupt);
        logic [31:0] rd;
        int          lat;
        bit          pre;
        bit          post;
        xfer(BUS_WR, addr, data, corrupt, rd, lat, pre, post);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_release"}, {31'd0, post}, 32'd1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                           input int exp_lat);
        logic [31:0] rd;
        int          lat;
        bit          pre;
        bit          post;
        xfer(BUS_RD, addr, 32'h0, 1'b0, rd, lat, pre, post);
        chk({tag, "_data"}, rd, exp_data);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_pre_z"}, {31'd0, pre}, 32'd1);
        chk({tag, "_post_z"}, {31'd0, post}, 32'd1);
    endtask

    task automatic abort_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        bus_if.BUS_addr = addr;
        bus_if.BUS_RW   = BUS_WR;
        bus_if.BUS_req  = 1'b1;
        m_wdata         = data;
        m_drive         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.BUS_req = 1'b0;
        m_drive        = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus_ready === 1'b1) seen = 1'b1;
        end
        chk({tag, "_no_ready"}, {31'd0, seen}, 32'd0);
        chk({tag, "_idle"}, 32'(u_ws2.r_state), 32'(ST_IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int n;

        clr             = 1'b1;
        m_drive         = 1'b0;
        m_wdata         = 32'h0;
        bus_if.BUS_addr = 32'h0;
        bus_if.BUS_RW   = BUS_RD;
        bus_if.BUS_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus_ready}, 32'd0);
        chk("rst_data", bus_data, 32'hFFFF_FFFF);
        chk("rst_state2", 32'(u_ws2.r_state), 32'(ST_IDLE));
        chk("rst_state0", 32'(u_ws0.r_state), 32'(ST_IDLE));
        chk("rst_cnt2", 32'(u_ws2.r_cnt), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        // Two wait states: ready three cycles after the request is sampled
        do_write("w_beef", 32'h0000_0010, 32'hDEAD_BEEF, 3, 1'b0);
        do_read("r_beef", 32'h0000_0010, 32'hDEAD_BEEF, 3);

        // Zero wait states, same word index in the other window
        do_write("w0_1010", 32'h0000_1010, 32'h1234_5678, 1, 1'b0);
        do_read("r0_1010", 32'h0000_1010, 32'h1234_5678, 1);
        do_read("r_beef_iso", 32'h0000_0010, 32'hDEAD_BEEF, 3);

        // Address and data changed after accept must not affect the write
        do_write("w_24", 32'h0000_0024, 32'h1111_2222, 3, 1'b0);
        do_write("w_20_corrupt", 32'h0000_0020, 32'hA5A5_0F0F, 3, 1'b1);
        do_read("r_20", 32'h0000_0020, 32'hA5A5_0F0F, 3);
        do_read("r_24", 32'h0000_0024, 32'h1111_2222, 3);

        // Out-of-window request is ignored by both slaves
        @(negedge clk);
        bus_if.BUS_addr = 32'h0000_2010;
        bus_if.BUS_RW   = BUS_RD;
        bus_if.BUS_req  = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus_ready === 1'b1) seen = 1'b1;
        end
        chk("miss_no_ready", {31'd0, seen}, 32'd0);
        chk("miss_data_z", bus_data, 32'hFFFF_FFFF);
        chk("miss_idle2", 32'(u_ws2.r_state), 32'(ST_IDLE));
        chk("miss_idle0", 32'(u_ws0.r_state), 32'(ST_IDLE));
        @(negedge clk);
        bus_if.BUS_req = 1'b0;

        // Master abort in the first wait cycle leaves memory untouched
        abort_write("abort", 32'h0000_0010, 32'hBAD0_BAD0);
        do_read("r_after_abort", 32'h0000_0010, 32'hDEAD_BEEF, 3);

        // Reset in the middle of WAIT of a write
        @(negedge clk);
        bus_if.BUS_addr = 32'h0000_0020;
        bus_if.BUS_RW   = BUS_WR;
        bus_if.BUS_req  = 1'b1;
        m_wdata         = 32'h0BAD_F00D;
        m_drive         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("rstw_state_async", 32'(u_ws2.r_state), 32'(ST_IDLE));
        chk("rstw_ready", {31'd0, bus_ready}, 32'd0);
        @(negedge clk);
        bus_if.BUS_req = 1'b0;
        m_drive        = 1'b0;
        clr            = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus_ready === 1'b1) seen = 1'b1;
        end
        chk("rstw_no_ready", {31'd0, seen}, 32'd0);
        do_read("r_after_rstw", 32'h0000_0020, 32'hA5A5_0F0F, 3);

        // Reset during ACK of a write: ready drops at once and the write is lost
        @(negedge clk);
        bus_if.BUS_addr = 32'h0000_0024;
        bus_if.BUS_RW   = BUS_WR;
        bus_if.BUS_req  = 1'b1;
        m_wdata         = 32'h5555_AAAA;
        m_drive         = 1'b1;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (bus_ready === 1'b1) seen = 1'b1;
        end
        chk("rsta_seen_ready", {31'd0, seen}, 32'd1);
        #2;
        clr = 1'b1;
        #1;
        chk("rsta_ready_drop", {31'd0, bus_ready}, 32'd0);
        @(negedge clk);
        bus_if.BUS_req = 1'b0;
        m_drive        = 1'b0;
        clr            = 1'b0;
        @(posedge clk);
        do_read("r_after_rsta", 32'h0000_0024, 32'h1111_2222, 3);

`ifdef SLAVE_STATS_EN
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("stat_rst_rd", 32'(stat_rd), 32'd0);
        chk("stat_rst_wr", 32'(stat_wr), 32'd0);
        do_read("s_r1", 32'h0000_0010, 32'hDEAD_BEEF, 3);
        do_read("s_r2", 32'h0000_0020, 32'hA5A5_0F0F, 3);
        do_write("s_w1", 32'h0000_0028, 32'h0102_0304, 3, 1'b0);
        abort_write("s_abort", 32'h0000_002C, 32'h0);
        do_write("s_w2", 32'h0000_002C, 32'h0506_0708, 3, 1'b0);
        do_read("s_r3", 32'h0000_0028, 32'h0102_0304, 3);
        chk("stat_rd", 32'(stat_rd), 32'd3);
        chk("stat_wr", 32'(stat_wr), 32'd2);
        force u_ws2.r_rd_count = 16'hFFFF;
        @(negedge clk);
        release u_ws2.r_rd_count;
        do_read("s_r4", 32'h0000_002C, 32'h0506_0708, 3);
        chk("stat_rd_sat", 32'(stat_rd), 32'h0000_FFFF);
        chk("stat_wr_hold", 32'(stat_wr), 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
